// File: rtl/uart_sender_pkg.sv
// uart_sender_pkg
//   Constants shared by the UART transmit path (and reusable by the receive side):
//   FSM state encodings, parity mode codes, the baud divisor computation and the
//   parity bit helper.
package uart_sender_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity mode codes
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Rounded clocks-per-bit; callers must keep the result >= 2.
  function automatic int calc_divisor(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  // Even mode: bit makes the total count of ones even. Odd mode: makes it odd.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_EVEN) ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
//   Bit-period counter for the transmitter. Counts 0..DIVISOR-1 while enabled and
//   pulses bit_tick on the last clock of every bit period.
// Ports
//   clk       in  system clock, rising edge
//   reset     in  asynchronous, active-low reset
//   clear     in  restart the bit period at 0 (frame start from idle)
//   en        in  count enable (transmitter busy)
//   bit_tick  out high during the final clock of a bit period
module uart_baud_gen #(
  parameter int DIVISOR = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
    end
  end

  assign bit_tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/uart_sender.sv
// uart_sender
//   UART transmitter: 8 data bits LSB first, optional odd/even parity, 1 or 2 stop
//   bits. A one-byte holding buffer lets a byte written mid-frame follow
//   back-to-back with no idle gap. All outputs are registered.
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   tx_data     in   byte to send, sampled only when tx_en=1
//   tx_en       in   one-cycle write strobe
//   tx          out  serial line, idle high
//   tx_status   out  1 = idle with holding buffer empty
//   tx_overrun  out  one-cycle pulse when a write is dropped (holding full)
module uart_sender
  import uart_sender_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx,
  output logic       tx_status,
  output logic       tx_overrun
);

  localparam int   DIVISOR   = calc_divisor(CLK_FREQ, BAUD);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  logic [2:0] state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] hold_reg, hold_next;
  logic       hold_full_reg, hold_full_next;
  logic       parity_reg, parity_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic       stop_cnt_reg, stop_cnt_next;
  logic       tx_reg, tx_next;
  logic       status_reg, status_next;
  logic       overrun_reg, overrun_next;

  logic busy;
  logic bit_tick;
  logic frame_end;
  logic baud_clear;

  assign busy       = (state_reg != ST_IDLE);
  assign frame_end  = (state_reg == ST_STOP) && bit_tick && (stop_cnt_reg == STOP_LAST);
  assign baud_clear = (state_reg == ST_IDLE) && tx_en;

  uart_baud_gen #(
    .DIVISOR (DIVISOR)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (baud_clear),
    .en       (busy),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    parity_next    = parity_reg;
    bit_cnt_next   = bit_cnt_reg;
    stop_cnt_next  = stop_cnt_reg;
    tx_next        = tx_reg;
    status_next    = status_reg;
    overrun_next   = 1'b0;

    // Mid-frame writes go to the holding buffer. The frame-end edge is handled
    // below because the buffer is being drained on that same edge.
    if (busy && tx_en && !frame_end) begin
      if (!hold_full_reg) begin
        hold_next      = tx_data;
        hold_full_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end

    case (state_reg)
      ST_IDLE: begin
        if (tx_en) begin
          state_next  = ST_START;
          shift_next  = tx_data;
          parity_next = parity_bit(tx_data, PARITY);
          tx_next     = 1'b0;
          status_next = 1'b0;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_next   = ST_DATA;
          bit_cnt_next = 3'd0;
          tx_next      = shift_reg[0];
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_reg == 3'd7) begin
            if (PARITY != PARITY_NONE) begin
              state_next = ST_PARITY;
              tx_next    = parity_reg;
            end else begin
              state_next    = ST_STOP;
              stop_cnt_next = 1'b0;
              tx_next       = 1'b1;
            end
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            tx_next      = shift_reg[1];
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_next    = ST_STOP;
          stop_cnt_next = 1'b0;
          tx_next       = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_cnt_reg == STOP_LAST) begin
            if (hold_full_reg) begin
              // Buffered byte goes out next; a simultaneous write refills the buffer.
              state_next     = ST_START;
              shift_next     = hold_reg;
              parity_next    = parity_bit(hold_reg, PARITY);
              tx_next        = 1'b0;
              hold_next      = tx_en ? tx_data : hold_reg;
              hold_full_next = tx_en;
            end else if (tx_en) begin
              // Write on the final stop clock starts directly, status stays low.
              state_next  = ST_START;
              shift_next  = tx_data;
              parity_next = parity_bit(tx_data, PARITY);
              tx_next     = 1'b0;
            end else begin
              state_next  = ST_IDLE;
              status_next = 1'b1;
            end
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: begin
        state_next  = ST_IDLE;
        tx_next     = 1'b1;
        status_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      parity_reg    <= 1'b0;
      bit_cnt_reg   <= '0;
      stop_cnt_reg  <= 1'b0;
      tx_reg        <= 1'b1;
      status_reg    <= 1'b1;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      parity_reg    <= parity_next;
      bit_cnt_reg   <= bit_cnt_next;
      stop_cnt_reg  <= stop_cnt_next;
      tx_reg        <= tx_next;
      status_reg    <= status_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign tx         = tx_reg;
  assign tx_status  = status_reg;
  assign tx_overrun = overrun_reg;

endmodule

// File: tb/tb_uart_sender.sv
// tb_uart_sender
//   Three transmitters (no parity, even parity, odd parity) with DIVISOR=16.
//   Stimulus pushes expected {parity, byte} words into per-DUT queues; line
//   monitors decode each frame and compare against the queue head.
module tb_uart_sender;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       en0, en1, en2;
  logic       tx0, tx1, tx2;
  logic       st0, st1, st2;
  logic       ov0, ov1, ov2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  int low_len[3];
  int last_low[3];
  int rises[3];
  int ovr_cnt[3];

  always #5 clk = ~clk;

  uart_sender #(.CLK_FREQ(16), .BAUD(1), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_en(en0),
    .tx(tx0), .tx_status(st0), .tx_overrun(ov0));
  uart_sender #(.CLK_FREQ(16), .BAUD(1), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_en(en1),
    .tx(tx1), .tx_status(st1), .tx_overrun(ov1));
  uart_sender #(.CLK_FREQ(16), .BAUD(1), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_en(en2),
    .tx(tx2), .tx_status(st2), .tx_overrun(ov2));

  function automatic logic line(input int id);
    case (id)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic status(input int id);
    case (id)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  function automatic logic ovr(input int id);
    case (id)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic [8:0] v);
    case (id)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int id, output logic [8:0] v, output bit found);
    found = 1'b0;
    v     = '0;
    case (id)
      0:       if (q0.size() > 0) begin v = q0.pop_front(); found = 1'b1; end
      1:       if (q1.size() > 0) begin v = q1.pop_front(); found = 1'b1; end
      default: if (q2.size() > 0) begin v = q2.pop_front(); found = 1'b1; end
    endcase
  endtask

  task automatic pulse(input int id, input logic [7:0] data);
    @(negedge clk);
    tx_data = data;
    case (id)
      0:       en0 = 1'b1;
      1:       en1 = 1'b1;
      default: en2 = 1'b1;
    endcase
    @(negedge clk);
    en0 = 1'b0;
    en1 = 1'b0;
    en2 = 1'b0;
    tx_data = ~data;  // bus changes after capture must not matter
    $display("tx dut%0d write %02h at %0t", id, data, $time);
  endtask

  task automatic wait_rise(input int id, input int prev, input int exp_len, input string name);
    int cyc;
    cyc = 0;
    while (rises[id] == prev && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (rises[id] == prev) check({name, "_timeout"}, 32'd0, 32'd1);
    else check(name, last_low[id], exp_len);
  endtask

  // Decode frames from one line; every bit must hold steady for all 16 clocks.
  task automatic monitor(input int id, input int npar);
    logic [11:0] bits;
    logic        first, v;
    bit          stable, aborted, found;
    logic [8:0]  got, exp;
    int          nb;
    nb = 10 + npar;
    forever begin
      do @(negedge clk); while (!(reset === 1'b1 && line(id) === 1'b0));
      stable  = 1'b1;
      aborted = 1'b0;
      bits    = '0;
      first   = 1'b0;
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < 16; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (reset !== 1'b1) aborted = 1'b1;
          v = line(id);
          if (k == 0) first = v;
          else if (v !== first) stable = 1'b0;
        end
        bits[b] = first;
        if (aborted) break;
      end
      if (!aborted) begin
        check("frame_shape", {29'd0, stable, bits[0], bits[nb-1]}, 32'b101);
        got = {(npar != 0) ? bits[9] : 1'b0, bits[8:1]};
        pop_exp(id, exp, found);
        if (!found) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame dut%0d: got %03h expected none", id, got);
        end else begin
          check("frame_data", {23'd0, got}, {23'd0, exp});
          $display("rx dut%0d data=%02h par=%b at %0t", id, got[7:0], got[8], $time);
        end
      end
    end
  endtask

  initial monitor(0, 0);
  initial monitor(1, 1);
  initial monitor(2, 1);

  // Track tx_status low-run lengths, rising edges and overrun pulses.
  initial begin
    for (int i = 0; i < 3; i++) begin
      low_len[i] = 0; last_low[i] = 0; rises[i] = 0; ovr_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (reset !== 1'b1) begin
          low_len[i] = 0;
        end else begin
          if (ovr(i) === 1'b1) ovr_cnt[i]++;
          if (status(i) === 1'b0) begin
            low_len[i]++;
          end else if (low_len[i] != 0) begin
            last_low[i] = low_len[i];
            rises[i]++;
            low_len[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r, o;
    reset   = 1'b1;
    tx_data = 8'h00;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("reset_tx", tx0, 1'b1);
    check("reset_status", st0, 1'b1);
    check("reset_overrun", ov0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Plain 8N1 frame
    r = rises[0];
    push_exp(0, {1'b0, 8'h55});
    pulse(0, 8'h55);
    check("start_latency_tx", tx0, 1'b0);
    check("start_latency_status", st0, 1'b0);
    wait_rise(0, r, 160, "len_8n1");

    // Even then odd parity on 0x07 (three ones)
    r = rises[1];
    push_exp(1, {1'b1, 8'h07});
    pulse(1, 8'h07);
    wait_rise(1, r, 176, "len_even");
    r = rises[2];
    push_exp(2, {1'b0, 8'h07});
    pulse(2, 8'h07);
    wait_rise(2, r, 176, "len_odd");

    // Second byte buffered mid-frame follows with no gap
    r = rises[0];
    push_exp(0, {1'b0, 8'hA5});
    push_exp(0, {1'b0, 8'h3C});
    pulse(0, 8'hA5);
    repeat (18) @(negedge clk);
    pulse(0, 8'h3C);
    wait_rise(0, r, 320, "len_burst");

    // Third write during one frame overruns
    r = rises[0];
    o = ovr_cnt[0];
    push_exp(0, {1'b0, 8'h11});
    push_exp(0, {1'b0, 8'h22});
    pulse(0, 8'h11);
    pulse(0, 8'h22);
    check("overrun_2nd", ov0, 1'b0);
    pulse(0, 8'h33);
    check("overrun_3rd", ov0, 1'b1);
    @(negedge clk);
    check("overrun_width", ov0, 1'b0);
    wait_rise(0, r, 320, "len_overrun");
    check("overrun_count", ovr_cnt[0] - o, 1);

    // Write on the last stop-bit clock with holding empty
    r = rises[0];
    push_exp(0, {1'b0, 8'h5A});
    push_exp(0, {1'b0, 8'hC3});
    pulse(0, 8'h5A);
    repeat (158) @(negedge clk);
    pulse(0, 8'hC3);
    check("b2b_start_tx", tx0, 1'b0);
    check("b2b_status", st0, 1'b0);
    wait_rise(0, r, 320, "len_b2b");

    // Reset in the middle of data bit 4 of 0xE7 (bit 4 is 0)
    pulse(0, 8'hE7);
    repeat (84) @(negedge clk);
    check("pre_reset_tx", tx0, 1'b0);
    reset = 1'b0;
    #1;
    check("async_reset_tx", tx0, 1'b1);
    check("async_reset_status", st0, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_idle_status", st0, 1'b1);
    check("post_reset_idle_tx", tx0, 1'b1);

    check("queues_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
